timepulse_gen: RTL

- Memory-cycle timepulse generator directly downstream of the clock-phase timer.
- Consumes the timer's PHS2 phase clock and the STOP request.
- Produces the twelve one-hot timepulses T01..T12 that sequence every memory cycle time (MCT), plus MCT parity and count, and stop status for monitor single-step.
- All logic is synchronous to the master CLOCK; PHS2 is treated as a level sampled on CLOCK, not as a clock.

---
 rtl/timepulse_gen.sv | 107 ++++++++++
 1 files changed

// File: rtl/timepulse_gen.sv
// Memory-cycle timepulse generator: steps a one-hot T01..T12 ring on each rising
// PHS2 level (sampled on CLOCK), with stop / monitor single-step / GOJAM restart control.
module timepulse_gen #(
    parameter int NUM_T = 12,
    parameter int CNT_W = 16
) (
    input  logic             CLOCK,
    input  logic             SIM_RST,
    input  logic             PHS2,
    input  logic             STOP,
    input  logic             MSTEP,
    input  logic             GOJAM,
    output logic [NUM_T-1:0] T,
    output logic [NUM_T-1:0] T_n,
    output logic             MCT_ODD,
    output logic [CNT_W-1:0] MCT_CNT,
    output logic             STOPPED
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOPPED,
        S_STEP
    } state_t;

    localparam logic [NUM_T-1:0] T_FIRST = NUM_T'(1);
    localparam logic [NUM_T-1:0] T_LAST  = {1'b1, {(NUM_T-1){1'b0}}};

    state_t state;
    logic   p2_d;
    logic   ms_d;
    logic   resume;
    logic   adv;
    logic   mstep_rise;

    assign adv        = PHS2 & ~p2_d;
    assign mstep_rise = MSTEP & ~ms_d;
    assign T_n        = ~T;

    // resume marks a T12 that is only a parking spot (after a stop or an abort):
    // the next advance goes to T01 without counting another completed MCT.
    always_ff @(posedge CLOCK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state   <= S_IDLE;
            T       <= '0;
            MCT_ODD <= 1'b0;
            MCT_CNT <= '0;
            STOPPED <= 1'b0;
            p2_d    <= 1'b1;
            ms_d    <= 1'b1;
            resume  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every branch reads the pre-edge T and state.
            p2_d <= PHS2;
            ms_d <= MSTEP;
            unique case (state)
                S_IDLE: begin
                    if (adv) begin
                        T     <= T_FIRST;
                        state <= S_RUN;
                    end
                end
                S_RUN, S_STEP: begin
                    if (adv) begin
                        if (GOJAM) begin
                            T      <= T_LAST;
                            state  <= S_RUN;
                            resume <= 1'b1;
                        end else if (T[NUM_T-1]) begin
                            if (resume) begin
                                T      <= T_FIRST;
                                resume <= 1'b0;
                            end else begin
                                MCT_CNT <= MCT_CNT + CNT_W'(1);
                                MCT_ODD <= ~MCT_ODD;
                                if (STOP) begin
                                    state   <= S_STOPPED;
                                    STOPPED <= 1'b1;
                                    resume  <= 1'b1;
                                end else begin
                                    T     <= T_FIRST;
                                    state <= S_RUN;
                                end
                            end
                        end else begin
                            T <= T << 1;
                        end
                    end
                end
                S_STOPPED: begin
                    if (adv && GOJAM) begin
                        state   <= S_RUN;
                        STOPPED <= 1'b0;
                    end else if (!STOP) begin
                        state   <= S_RUN;
                        STOPPED <= 1'b0;
                    end else if (mstep_rise) begin
                        state   <= S_STEP;
                        STOPPED <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
